// File: rtl/uart_tx_buffer.sv
// ---------------------------------------------------------------------------
// uart_tx_buffer
//
// Byte FIFO plus launch sequencer feeding a UART transmitter's
// data_in / data_in_valid pair. Producers push bytes at full clock rate.
// The sequencer pops one byte at a time, but only while the UART is not busy.
// It issues a single-cycle valid pulse and holds uart_data stable until the
// UART drops busy at the end of the frame.
// If the UART never raises busy after a launch, the same byte is relaunched
// after LAUNCH_TIMEOUT clocks.
//
// Optional feature (macro UART_TX_CRLF_EN):
//   When defined, a popped 8'h0A is sent as 8'h0D followed by 8'h0A. Both
//   frames come from a single FIFO pop, and tx_active stays high across them.
//   When undefined, bytes are sent verbatim.
//
// Ports:
//   clk50MHz        in   system clock, rising edge
//   rst_n           in   synchronous active-low reset
//   wr_data[7:0]    in   byte to enqueue
//   wr_en           in   push strobe, accepted when full==0
//   full            out  FIFO holds DEPTH bytes
//   empty           out  FIFO holds 0 bytes
//   level[ADDR_W:0] out  occupancy 0..DEPTH
//   overflow        out  sticky: push attempted while full
//   uart_busy       in   UART busy
//   uart_data[7:0]  out  to UART data_in
//   uart_data_valid out  to UART data_in_valid, single-cycle pulse
//   tx_active       out  high from pop until the frame completes
// ---------------------------------------------------------------------------
module uart_tx_buffer #(
  parameter int DEPTH          = 16,
  parameter int ADDR_W         = 4,
  parameter int LAUNCH_TIMEOUT = 4
) (
  input  logic              clk50MHz,
  input  logic              rst_n,
  input  logic [7:0]        wr_data,
  input  logic              wr_en,
  output logic              full,
  output logic              empty,
  output logic [ADDR_W:0]   level,
  output logic              overflow,
  input  logic              uart_busy,
  output logic [7:0]        uart_data,
  output logic              uart_data_valid,
  output logic              tx_active
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LAUNCH = 3'd1,
    S_ACK    = 3'd2,
`ifdef UART_TX_CRLF_EN
    S_WAIT   = 3'd3,
    S_LF     = 3'd4
`else
    S_WAIT   = 3'd3
`endif
  } state_t;

  localparam logic [ADDR_W:0]   LEVEL_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   LEVEL_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LEVEL_ZERO = {(ADDR_W+1){1'b0}};
  localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ZERO   = {ADDR_W{1'b0}};
  localparam logic [7:0]        TMO_LAST   = 8'(LAUNCH_TIMEOUT - 1);

  logic [7:0]        mem_r [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_r;
  logic [ADDR_W-1:0] rd_ptr_r;
  logic [ADDR_W:0]   level_r;
  logic              full_r;
  logic              empty_r;
  logic              overflow_r;

  state_t            state_r;
  logic [7:0]        uart_data_r;
  logic              uart_data_valid_r;
  logic              tx_active_r;
  logic [7:0]        tmo_r;
`ifdef UART_TX_CRLF_EN
  logic              lf_pending_r;
`endif

  logic              push_s;
  logic              pop_s;
  logic [ADDR_W:0]   level_nxt_s;
  logic [7:0]        head_s;

  // Push/pop qualification and next occupancy.
  // A push while full is dropped even if a pop happens in the same cycle.
  always_comb begin
    push_s      = wr_en & ~full_r;
    pop_s       = (state_r == S_IDLE) & ~empty_r & ~uart_busy;
    head_s      = mem_r[rd_ptr_r];
    level_nxt_s = level_r;
    case ({push_s, pop_s})
      2'b10:   level_nxt_s = level_r + LEVEL_ONE;
      2'b01:   level_nxt_s = level_r - LEVEL_ONE;
      default: level_nxt_s = level_r;
    endcase
  end

  // FIFO storage; contents need no reset because level gates every read.
  always_ff @(posedge clk50MHz) begin
    if (push_s) begin
      mem_r[wr_ptr_r] <= wr_data;
    end
  end

  // FIFO pointers, occupancy, status flags and sticky overflow.
  always_ff @(posedge clk50MHz) begin
    if (!rst_n) begin
      wr_ptr_r   <= PTR_ZERO;
      rd_ptr_r   <= PTR_ZERO;
      level_r    <= LEVEL_ZERO;
      full_r     <= 1'b0;
      empty_r    <= 1'b1;
      overflow_r <= 1'b0;
    end else begin
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      level_r <= level_nxt_s;
      full_r  <= (level_nxt_s == LEVEL_FULL);
      empty_r <= (level_nxt_s == LEVEL_ZERO);
      if (wr_en && full_r) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Launch sequencer. uart_data_valid is set on entry to S_LAUNCH,
  // so it is high exactly during the S_LAUNCH cycle.
  always_ff @(posedge clk50MHz) begin
    if (!rst_n) begin
      state_r           <= S_IDLE;
      uart_data_r       <= 8'h00;
      uart_data_valid_r <= 1'b0;
      tx_active_r       <= 1'b0;
      tmo_r             <= 8'd0;
`ifdef UART_TX_CRLF_EN
      lf_pending_r      <= 1'b0;
`endif
    end else begin
      uart_data_valid_r <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (pop_s) begin
`ifdef UART_TX_CRLF_EN
            // LF is preceded by CR. The LF itself is replayed from S_LF.
            if (head_s == 8'h0A) begin
              uart_data_r  <= 8'h0D;
              lf_pending_r <= 1'b1;
            end else begin
              uart_data_r  <= head_s;
            end
`else
            uart_data_r       <= head_s;
`endif
            tx_active_r       <= 1'b1;
            uart_data_valid_r <= 1'b1;
            state_r           <= S_LAUNCH;
          end
        end
        S_LAUNCH: begin
          tmo_r   <= 8'd0;
          state_r <= S_ACK;
        end
        S_ACK: begin
          if (uart_busy) begin
            state_r <= S_WAIT;
          end else if (tmo_r == TMO_LAST) begin
            // UART ignored the pulse; relaunch the same byte.
            uart_data_valid_r <= 1'b1;
            state_r           <= S_LAUNCH;
          end else begin
            tmo_r <= tmo_r + 8'd1;
          end
        end
        S_WAIT: begin
          if (!uart_busy) begin
`ifdef UART_TX_CRLF_EN
            if (lf_pending_r) begin
              lf_pending_r <= 1'b0;
              state_r      <= S_LF;
            end else begin
              tx_active_r  <= 1'b0;
              state_r      <= S_IDLE;
            end
`else
            tx_active_r <= 1'b0;
            state_r     <= S_IDLE;
`endif
          end
        end
`ifdef UART_TX_CRLF_EN
        S_LF: begin
          if (!uart_busy) begin
            uart_data_r       <= 8'h0A;
            uart_data_valid_r <= 1'b1;
            state_r           <= S_LAUNCH;
          end
        end
`endif
        default: begin
          tx_active_r <= 1'b0;
          state_r     <= S_IDLE;
        end
      endcase
    end
  end

  assign full            = full_r;
  assign empty           = empty_r;
  assign level           = level_r;
  assign overflow        = overflow_r;
  assign uart_data       = uart_data_r;
  assign uart_data_valid = uart_data_valid_r;
  assign tx_active       = tx_active_r;

endmodule
